pcs_lane_tx: RTL and testbench
==============================

Name: pcs_lane_tx

Overview:
Per-lane transmit stage fed by one lane of the 4-lane distributor (txdata/txdata_en/txsync in, ideal out).
- Buffers unit words in a small FIFO.
- Frames each word as a 2-bit-header block (data or control).
- Scrambles data payloads; emits fixed sync and idle control blocks.
- Presents one block per accepted in_ready cycle to the serializer/gearbox.
- Four instances exist, one per lane.

Parameters:
UNITWIDTH, 64, payload width per lane word
DEPTH, 4, FIFO entries (power of 2, >=2)
SYNC_WORD, 64'h4B_5A_A5_B4_1E_E1_78_87, control payload marking a lane-alignment sync block
IDLE_WORD, 64'h07_07_07_07_07_07_07_1E, control payload sent when FIFO empty

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
in_enable  in  1  global clock-enable; when low, all state holds
in_txdata  in  UNITWIDTH  lane word from distributor
in_txdata_en  in  1  push strobe
in_txsync  in  1  with en: push sync marker instead of data
out_ideal  out  1  lane can accept a push this cycle (to distributor in_idealN)
in_ready  in  1  downstream consumes out_block this cycle
out_block  out  UNITWIDTH+2  {header[1:0], payload}; header in bits [UNITWIDTH+1:UNITWIDTH]
out_block_valid  out  1  out_block meaningful
out_sync_sent  out  1  one-cycle pulse when a sync block is loaded into out_block
out_overflow  out  1  sticky: push attempted while full

Behaviour:
- Reset is synchronous on clk when reset_n=0. It takes priority over in_enable and clears a mid-operation FIFO without draining it.
  - FIFO count=0; rd/wr pointers=0.
  - Scrambler state = all ones (58 bits).
  - out_block=0; out_block_valid=0; out_sync_sent=0; out_overflow=0.
- in_enable=0: no push, no pop, registers hold; out_ideal=0.
- out_ideal = in_enable & (count < DEPTH). It is combinational from registered count and has no dependence on in_txdata_en, so there is no loop with the distributor.
- Push: in_enable & in_txdata_en & count<DEPTH.
  - Stores {in_txsync, in_txdata}.
  - With in_txsync=1 the data is stored but ignored at output.
- Overflow: in_txdata_en while count==DEPTH sets out_overflow. The word is dropped and FIFO state is unchanged.
- Output register updates when in_enable & (in_ready | !out_block_valid). After reset it fills on the first enabled cycle; out_block_valid=1 thereafter.
  - FIFO non-empty, head is data: pop. out_block = {2'b01, scramble(payload)}.
  - FIFO non-empty, head is sync: pop. out_block = {2'b10, SYNC_WORD}; out_sync_sent=1 for that cycle. The scrambler state does not advance.
  - FIFO empty: out_block = {2'b10, IDLE_WORD}. Scrambler does not advance; no pop.
- out_sync_sent is 0 in every cycle it is not set by a sync load.
- Simultaneous push and pop: count is unchanged; both pointers advance.
  - Push at count==DEPTH coinciding with a pop is still refused, because out_ideal is already 0.
- Pointers wrap modulo DEPTH.
- Latency: a push at cycle N with FIFO empty and output register consumable appears on out_block at N+2.
  - N+1: entry visible at head.
  - N+2: output register loaded.
- Scrambler: self-synchronous, polynomial 1+x^39+x^58, applied LSB first across the payload.
  - Per bit: o = d ^ S[38] ^ S[57]; then S = {S[56:0], o}.
  - All UNITWIDTH bits are processed in one cycle.

Decomposition:
- Shared package (pcs defines): UNITWIDTH, header codes HDR_DATA=2'b01 and HDR_CTRL=2'b10, SYNC_WORD, IDLE_WORD, scrambler taps 39/58.
- Sub-module pcs_scrambler58: combinational next-state/output function (state in, data in, scrambled out, state out).
  - The state register stays in pcs_lane_tx so it can be held on sync/idle blocks.
- The FIFO is inline; it is too small to justify a separate module.

Test Plan:
- Reset then idle, in_ready=1 -> out_block_valid=1 from first enabled cycle; every block = {2'b10, IDLE_WORD}; out_ideal=1; scrambler state stays all ones.
- Push data 64'h0 with state all ones, in_ready=1 -> after 2 cycles, header 01 and payload equal to reference-model scramble of 0 from seed all ones; a second 64'h0 yields the model's next value.
- Push sync (en=1, txsync=1, data=64'hDEAD) between two data words -> order data, {10, SYNC_WORD}, data; out_sync_sent is a single pulse; scrambler continuity holds across the sync.
- Hold in_ready=0 and push 5 words with en forced regardless of out_ideal -> out_ideal=0 after 4 pushes; 5th sets out_overflow=1 sticky; releasing in_ready yields exactly words 1-4 in order.
- Full FIFO with in_ready=1 and push on every cycle out_ideal allows -> sustained 1 block/cycle, no overflow, correct order across pointer wrap.
- reset_n=0 mid-stream with 3 words queued -> next cycle count=0, out_overflow=0, out_block_valid=0; queued words never appear; then idle blocks resume.

Source files
------------

// File: rtl/pcs_lane_tx_pkg.sv
// Shared PCS lane definitions: widths, 2-bit block headers, control payloads, scrambler taps.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pcs_lane_tx_pkg;

  localparam int PCS_UNITWIDTH = 64;

  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTRL = 2'b10;

  localparam logic [63:0] PCS_SYNC_WORD = 64'h4B_5A_A5_B4_1E_E1_78_87;
  localparam logic [63:0] PCS_IDLE_WORD = 64'h07_07_07_07_07_07_07_1E;

  // Self-synchronous scrambler 1 + x^39 + x^58
  localparam int SCR_LEN = 58;
  localparam int SCR_TAP = 39;

endpackage

// File: rtl/pcs_scrambler58.sv
// Combinational 1+x^39+x^58 scrambler step over a full word, LSB first.
// Latency: 0 cycles (pure function of state_in and data_in).
// Backpressure: none; the caller decides when to commit state_out.
module pcs_scrambler58
  import pcs_lane_tx_pkg::*;
#(
  parameter int W = PCS_UNITWIDTH
) (
  input  logic [SCR_LEN-1:0] state_in,
  input  logic [W-1:0]       data_in,
  output logic [W-1:0]       data_out,
  output logic [SCR_LEN-1:0] state_out
);

  logic [SCR_LEN-1:0] s;
  logic               o;

  // Serially scramble every payload bit, feeding each output bit back into the shift state
  always_comb begin
    s        = state_in;
    o        = 1'b0;
    data_out = '0;
    for (int i = 0; i < W; i++) begin
      o           = data_in[i] ^ s[SCR_TAP-1] ^ s[SCR_LEN-1];
      data_out[i] = o;
      s           = {s[SCR_LEN-2:0], o};
    end
    state_out = s;
  end

endmodule

// File: rtl/pcs_lane_tx.sv
// Per-lane TX: FIFO of lane words, 2-bit-header framing, data scrambling, sync/idle insertion.
// Latency: push at cycle N appears on out_block at N+2 when the FIFO is empty and output is consumable.
// Backpressure: out_ideal drops when the FIFO is full; output register holds while in_ready=0.
module pcs_lane_tx
  import pcs_lane_tx_pkg::*;
#(
  parameter int                   UNITWIDTH = PCS_UNITWIDTH,
  parameter int                   DEPTH     = 4,
  parameter logic [UNITWIDTH-1:0] SYNC_WORD = PCS_SYNC_WORD,
  parameter logic [UNITWIDTH-1:0] IDLE_WORD = PCS_IDLE_WORD
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_enable,
  input  logic [UNITWIDTH-1:0] in_txdata,
  input  logic                 in_txdata_en,
  input  logic                 in_txsync,
  output logic                 out_ideal,
  input  logic                 in_ready,
  output logic [UNITWIDTH+1:0] out_block,
  output logic                 out_block_valid,
  output logic                 out_sync_sent,
  output logic                 out_overflow
);

  localparam int             AW        = $clog2(DEPTH);
  localparam logic [AW:0]    DEPTH_CNT = (AW+1)'(DEPTH);

  // Each entry is {sync_flag, payload}
  logic [UNITWIDTH:0]   mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;

  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 load;
  logic                 pop;
  logic [UNITWIDTH:0]   head;
  logic                 head_sync;

  logic [SCR_LEN-1:0]   scr_state;
  logic [SCR_LEN-1:0]   scr_next;
  logic [UNITWIDTH-1:0] scr_data;

  assign full      = (count == DEPTH_CNT);
  assign empty     = (count == '0);
  assign head      = mem[rd_ptr];
  assign head_sync = head[UNITWIDTH];

  // out_ideal depends only on registered count so the distributor sees no combinational loop
  assign out_ideal = in_enable & ~full;
  assign push      = in_enable & in_txdata_en & ~full;
  assign load      = in_enable & (in_ready | ~out_block_valid);
  assign pop       = load & ~empty;

  pcs_scrambler58 #(.W(UNITWIDTH)) u_scr (
    .state_in  (scr_state),
    .data_in   (head[UNITWIDTH-1:0]),
    .data_out  (scr_data),
    .state_out (scr_next)
  );

  // FIFO storage; stale entries are harmless because reset clears the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_txsync, in_txdata};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Scrambler state only advances on data blocks; sync and idle blocks leave it untouched
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scr_state <= '1;
    end else if (pop && !head_sync) begin
      scr_state <= scr_next;
    end
  end

  // Output block register: data, sync or idle depending on FIFO head
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_block       <= '0;
      out_block_valid <= 1'b0;
    end else if (load) begin
      out_block_valid <= 1'b1;
      if (empty) begin
        out_block <= {HDR_CTRL, IDLE_WORD};
      end else if (head_sync) begin
        out_block <= {HDR_CTRL, SYNC_WORD};
      end else begin
        out_block <= {HDR_DATA, scr_data};
      end
    end
  end

  // Sync pulse is high only in the cycle following a sync load
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_sync_sent <= 1'b0;
    end else begin
      out_sync_sent <= pop & head_sync;
    end
  end

  // Sticky overflow flag: push strobe seen while the FIFO is full
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_overflow <= 1'b0;
    end else if (in_enable && in_txdata_en && full) begin
      out_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pcs_lane_tx.sv
module tb_pcs_lane_tx;

  localparam logic [63:0] SYNC = 64'h4B5AA5B41EE17887;
  localparam logic [63:0] IDLE = 64'h070707070707071E;
  localparam logic [65:0] IDLE_BLK = {2'b10, IDLE};
  localparam logic [65:0] SYNC_BLK = {2'b10, SYNC};

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_enable;
  logic [63:0] in_txdata;
  logic        in_txdata_en;
  logic        in_txsync;
  logic        out_ideal;
  logic        in_ready;
  logic [65:0] out_block;
  logic        out_block_valid;
  logic        out_sync_sent;
  logic        out_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [57:0] tb_scr;

  always #5 clk = ~clk;

  pcs_lane_tx dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .in_enable       (in_enable),
    .in_txdata       (in_txdata),
    .in_txdata_en    (in_txdata_en),
    .in_txsync       (in_txsync),
    .out_ideal       (out_ideal),
    .in_ready        (in_ready),
    .out_block       (out_block),
    .out_block_valid (out_block_valid),
    .out_sync_sent   (out_sync_sent),
    .out_overflow    (out_overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference scrambler written as a bit stream: y[0..57] is history (oldest first),
  // y[58+i] is output bit i; o_i = d_i ^ out[-39] ^ out[-58].
  task automatic scr_model(input logic [63:0] d, input logic [57:0] s,
                           output logic [63:0] o, output logic [57:0] so);
    logic [121:0] y;
    y = '0;
    o = '0;
    for (int k = 0; k < 58; k++) y[57-k] = s[k];
    for (int i = 0; i < 64; i++) begin
      y[58+i] = d[i] ^ y[19+i] ^ y[i];
      o[i]    = y[58+i];
    end
    for (int k = 0; k < 58; k++) so[k] = y[121-k];
  endtask

  // Next expected data block from the model, advancing model state
  task automatic next_data_blk(input logic [63:0] d, output logic [65:0] blk);
    logic [63:0] o;
    logic [57:0] ns;
    scr_model(d, tb_scr, o, ns);
    tb_scr = ns;
    blk = {2'b01, o};
  endtask

  function automatic logic [63:0] word(input int i);
    return 64'hB2B0_0000_0000_0000 | 64'(i * 37 + 1);
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; in_enable = 1'b1; in_ready = 1'b1;
    in_txdata_en = 1'b0; in_txsync = 1'b0; in_txdata = '0;
    tick(); tick();
    n_checks++; if (out_block_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_block_valid); end
    n_checks++; if (out_block !== 66'h0) begin n_fail++; $display("FAIL reset_block: got %h expected 0", out_block); end
    n_checks++; if (out_sync_sent !== 1'b0) begin n_fail++; $display("FAIL reset_sync_sent: got %b expected 0", out_sync_sent); end
    n_checks++; if (out_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", out_overflow); end
    n_checks++; if (out_ideal !== 1'b1) begin n_fail++; $display("FAIL reset_ideal: got %b expected 1", out_ideal); end
    reset_n = 1'b1;
    tb_scr = '1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (out_block_valid !== 1'b1) begin n_fail++; $display("FAIL idle_valid[%0d]: got %b expected 1", c, out_block_valid); end
      n_checks++; if (out_block !== IDLE_BLK) begin n_fail++; $display("FAIL idle_block[%0d]: got %h expected %h", c, out_block, IDLE_BLK); end
      n_checks++; if (out_ideal !== 1'b1) begin n_fail++; $display("FAIL idle_ideal[%0d]: got %b expected 1", c, out_ideal); end
    end
  endtask

  task automatic test_data();
    logic [65:0] exp;
    in_txdata = 64'h0; in_txsync = 1'b0; in_txdata_en = 1'b1;
    tick();
    in_txdata_en = 1'b0;
    n_checks++; if (out_block !== IDLE_BLK) begin n_fail++; $display("FAIL data_not_early: got %h expected %h", out_block, IDLE_BLK); end
    tick();
    // Hand-derived: zero from all-ones seed sets exactly bits 39..57
    n_checks++; if (out_block !== {2'b01, 64'h03FF_FF80_0000_0000}) begin n_fail++; $display("FAIL data0_const: got %h expected %h", out_block, {2'b01, 64'h03FF_FF80_0000_0000}); end
    next_data_blk(64'h0, exp);
    n_checks++; if (out_block !== exp) begin n_fail++; $display("FAIL data0_model: got %h expected %h", out_block, exp); end
    in_txdata_en = 1'b1;
    tick();
    in_txdata_en = 1'b0;
    tick();
    next_data_blk(64'h0, exp);
    n_checks++; if (out_block !== exp) begin n_fail++; $display("FAIL data1_model: got %h expected %h", out_block, exp); end
    tick();
    n_checks++; if (out_block !== IDLE_BLK) begin n_fail++; $display("FAIL data_idle_after: got %h expected %h", out_block, IDLE_BLK); end
  endtask

  task automatic test_sync();
    logic [65:0] exp;
    in_txdata = 64'h0123_4567_89AB_CDEF; in_txsync = 1'b0; in_txdata_en = 1'b1;
    tick();
    in_txdata = 64'hDEAD; in_txsync = 1'b1;
    tick();
    next_data_blk(64'h0123_4567_89AB_CDEF, exp);
    n_checks++; if (out_block !== exp) begin n_fail++; $display("FAIL sync_first_data: got %h expected %h", out_block, exp); end
    n_checks++; if (out_sync_sent !== 1'b0) begin n_fail++; $display("FAIL sync_pulse_pre: got %b expected 0", out_sync_sent); end
    in_txdata = 64'hFEDC_BA98_7654_3210; in_txsync = 1'b0;
    tick();
    in_txdata_en = 1'b0;
    n_checks++; if (out_block !== SYNC_BLK) begin n_fail++; $display("FAIL sync_block: got %h expected %h", out_block, SYNC_BLK); end
    n_checks++; if (out_sync_sent !== 1'b1) begin n_fail++; $display("FAIL sync_pulse: got %b expected 1", out_sync_sent); end
    tick();
    next_data_blk(64'hFEDC_BA98_7654_3210, exp);
    n_checks++; if (out_block !== exp) begin n_fail++; $display("FAIL sync_second_data: got %h expected %h", out_block, exp); end
    n_checks++; if (out_sync_sent !== 1'b0) begin n_fail++; $display("FAIL sync_pulse_post: got %b expected 0", out_sync_sent); end
    tick();
    n_checks++; if (out_block !== IDLE_BLK) begin n_fail++; $display("FAIL sync_idle_after: got %h expected %h", out_block, IDLE_BLK); end
  endtask

  task automatic test_overflow();
    logic [65:0] exp;
    in_ready = 1'b0; in_txsync = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (out_ideal !== (i < 4)) begin n_fail++; $display("FAIL ovf_ideal[%0d]: got %b expected %b", i, out_ideal, (i < 4)); end
      n_checks++; if (out_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early[%0d]: got %b expected 0", i, out_overflow); end
      in_txdata = word(100 + i); in_txdata_en = 1'b1;
      tick();
    end
    in_txdata_en = 1'b0;
    n_checks++; if (out_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", out_overflow); end
    tick();
    n_checks++; if (out_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", out_overflow); end
    n_checks++; if (out_block !== IDLE_BLK) begin n_fail++; $display("FAIL ovf_held: got %h expected %h", out_block, IDLE_BLK); end
    in_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      next_data_blk(word(100 + i), exp);
      n_checks++; if (out_block !== exp) begin n_fail++; $display("FAIL ovf_drain[%0d]: got %h expected %h", i, out_block, exp); end
    end
    tick();
    n_checks++; if (out_block !== IDLE_BLK) begin n_fail++; $display("FAIL ovf_no_fifth: got %h expected %h", out_block, IDLE_BLK); end
    n_checks++; if (out_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky_end: got %b expected 1", out_overflow); end
  endtask

  task automatic test_enable();
    in_ready = 1'b1; in_enable = 1'b0; in_txdata = word(7); in_txdata_en = 1'b1;
    #1;
    n_checks++; if (out_ideal !== 1'b0) begin n_fail++; $display("FAIL en_ideal_low: got %b expected 0", out_ideal); end
    tick();
    in_enable = 1'b1; in_txdata_en = 1'b0;
    tick();
    tick();
    n_checks++; if (out_block !== IDLE_BLK) begin n_fail++; $display("FAIL en_no_push: got %h expected %h", out_block, IDLE_BLK); end
  endtask

  task automatic test_reset_mid();
    in_ready = 1'b0; in_txsync = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_txdata = word(200 + i); in_txdata_en = 1'b1;
      tick();
    end
    in_txdata_en = 1'b0;
    reset_n = 1'b0;
    tick();
    n_checks++; if (out_block_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", out_block_valid); end
    n_checks++; if (out_overflow !== 1'b0) begin n_fail++; $display("FAIL mid_overflow: got %b expected 0", out_overflow); end
    n_checks++; if (out_ideal !== 1'b1) begin n_fail++; $display("FAIL mid_ideal: got %b expected 1", out_ideal); end
    reset_n = 1'b1; in_ready = 1'b1;
    tb_scr = '1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++; if (out_block !== IDLE_BLK) begin n_fail++; $display("FAIL mid_idle[%0d]: got %h expected %h", c, out_block, IDLE_BLK); end
    end
  endtask

  task automatic test_back_to_back();
    logic [65:0] exp;
    int          np;
    reset_n = 1'b0; in_txdata_en = 1'b0; in_txsync = 1'b0;
    tick();
    reset_n = 1'b1; in_ready = 1'b0;
    tb_scr = '1;
    np = 0;
    for (int i = 0; i < 4; i++) begin
      in_txdata = word(np); in_txdata_en = 1'b1; np++;
      tick();
    end
    in_txdata_en = 1'b0;
    n_checks++; if (out_ideal !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got %b expected 0", out_ideal); end
    in_ready = 1'b1;
    for (int nc = 0; nc < 12; nc++) begin
      if (out_ideal && np < 12) begin
        in_txdata = word(np); in_txdata_en = 1'b1; np++;
      end else begin
        in_txdata_en = 1'b0;
      end
      tick();
      next_data_blk(word(nc), exp);
      n_checks++; if (out_block !== exp) begin n_fail++; $display("FAIL b2b_word[%0d]: got %h expected %h", nc, out_block, exp); end
    end
    in_txdata_en = 1'b0;
    n_checks++; if (np !== 12) begin n_fail++; $display("FAIL b2b_pushed: got %0d expected 12", np); end
    n_checks++; if (out_overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow: got %b expected 0", out_overflow); end
    tick();
    n_checks++; if (out_block !== IDLE_BLK) begin n_fail++; $display("FAIL b2b_idle_after: got %h expected %h", out_block, IDLE_BLK); end
  endtask

  initial begin
    test_reset();
    test_data();
    test_sync();
    test_overflow();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
